// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional two-entry skid buffer,
// synchronous flush and a saturating back-pressure counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    // State value doubles as the number of held beats.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_in_ready;
    logic [CNT_W-1:0]  r_stall;

    logic w_out_valid;
    logic w_in_ready;
    logic w_accept;
    logic w_take;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_out_valid = (r_state != ST_EMPTY);
    // Skid mode: ready comes from a flop; single mode: ready passes downstream ready through.
    assign w_in_ready  = (SKID != 0) ? r_in_ready : (!w_out_valid || out_ready);
    assign w_accept    = in_valid && w_in_ready;
    assign w_take      = w_out_valid && out_ready;

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_data     = r_main;
    assign occupancy    = r_state;
    assign stall_cycles = r_stall;

    // Next-state and data-load selection; flush overrides everything.
    // In single-register mode an accept while ONE implies a take, so the
    // ONE->FULL branch is unreachable there without a mode check.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt    = ST_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_take) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_take) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_take) begin
                    w_state_nxt      = ST_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt      = ST_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    // State register and registered upstream ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    // Payload registers load only on accept or skid-to-main transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= in_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    // Saturating back-pressure counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (cnt_clr) begin
            r_stall <= '0;
        end else if (w_out_valid && !out_ready && (r_stall != '1)) begin
            r_stall <= r_stall + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: queue-based reference model, directed vector table,
// hand sequences for saturation/reset, and a randomized phase.
module tb_pipe_stage_reg;

    logic clk;
    logic rst_n;

    // Instance A (skid, 16-bit counter) and C (skid, 4-bit counter) share inputs.
    logic        a_in_valid, a_out_ready, a_flush, a_cnt_clr;
    logic [31:0] a_in_data;
    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [1:0]  a_occ;
    logic [15:0] a_stall;
    logic        c_in_ready, c_out_valid;
    logic [31:0] c_out_data;
    logic [1:0]  c_occ;
    logic [3:0]  c_stall;
    // Instance B (single register).
    logic        b_in_valid, b_out_ready, b_flush, b_cnt_clr;
    logic [31:0] b_in_data;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [1:0]  b_occ;
    logic [15:0] b_stall;

    pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .flush(a_flush), .cnt_clr(a_cnt_clr), .occupancy(a_occ), .stall_cycles(a_stall)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID(0), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .flush(b_flush), .cnt_clr(b_cnt_clr), .occupancy(b_occ), .stall_cycles(b_stall)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(4)) u_dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(c_in_ready), .in_data(a_in_data),
        .out_valid(c_out_valid), .out_ready(a_out_ready), .out_data(c_out_data),
        .flush(a_flush), .cnt_clr(a_cnt_clr), .occupancy(c_occ), .stall_cycles(c_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents per instance and counter values.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int unsigned cnt_a, cnt_b, cnt_c;
    logic [31:0] b_got[$];

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic        ir;
        logic [1:0]  occ;
        logic [31:0] od;
        int unsigned st;
    } vec_t;

    vec_t tv[$];
    vec_t tv_cur;
    logic tv_en = 1'b0;

    function automatic vec_t mk(logic iv, logic [31:0] d, logic ordy, logic fl,
                                logic ov, logic ir, logic [1:0] occ, logic [31:0] od,
                                int unsigned st);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.ir = ir; v.occ = occ; v.od = od; v.st = st;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic check_model();
        int unsigned ea;
        int unsigned eb;
        ea = qa.size();
        eb = qb.size();
        chk("a_valid", 32'(a_out_valid), 32'(ea != 0));
        chk("a_ready", 32'(a_in_ready), 32'(ea < 2));
        chk("a_occ", 32'(a_occ), ea);
        if (ea != 0) chk("a_data", a_out_data, qa[0]);
        chk("a_stall", 32'(a_stall), cnt_a);
        chk("c_valid", 32'(c_out_valid), 32'(ea != 0));
        chk("c_ready", 32'(c_in_ready), 32'(ea < 2));
        if (ea != 0) chk("c_data", c_out_data, qa[0]);
        chk("c_stall", 32'(c_stall), cnt_c);
        chk("b_valid", 32'(b_out_valid), 32'(eb != 0));
        chk("b_ready", 32'(b_in_ready), 32'((eb == 0) || b_out_ready));
        chk("b_occ", 32'(b_occ), eb);
        if (eb != 0) chk("b_data", b_out_data, qb[0]);
        chk("b_stall", 32'(b_stall), cnt_b);
        if (b_out_valid && b_out_ready) b_got.push_back(b_out_data);
        if (tv_en) begin
            chk("tv_valid", 32'(a_out_valid), 32'(tv_cur.ov));
            chk("tv_ready", 32'(a_in_ready), 32'(tv_cur.ir));
            chk("tv_occ", 32'(a_occ), 32'(tv_cur.occ));
            if (tv_cur.ov) chk("tv_data", a_out_data, tv_cur.od);
            chk("tv_stall", 32'(a_stall), tv_cur.st);
        end
    endtask

    task automatic update_model();
        logic acc, tk;
        // Counters look at the pre-edge occupancy.
        if (a_cnt_clr) begin
            cnt_a = 0;
            cnt_c = 0;
        end else if (qa.size() != 0 && !a_out_ready) begin
            if (cnt_a < 65535) cnt_a++;
            if (cnt_c < 15) cnt_c++;
        end
        if (b_cnt_clr) cnt_b = 0;
        else if (qb.size() != 0 && !b_out_ready && cnt_b < 65535) cnt_b++;

        acc = a_in_valid && (qa.size() < 2);
        tk  = (qa.size() != 0) && a_out_ready;
        if (a_flush) qa.delete();
        else begin
            if (tk) void'(qa.pop_front());
            if (acc) qa.push_back(a_in_data);
        end

        acc = b_in_valid && ((qb.size() == 0) || b_out_ready);
        tk  = (qb.size() != 0) && b_out_ready;
        if (b_flush) qb.delete();
        else begin
            if (tk) void'(qb.pop_front());
            if (acc) qb.push_back(b_in_data);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_flush = 1'b0; a_cnt_clr = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0; b_cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        qa.delete(); qb.delete();
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] nxt;
        // Directed vectors for instance A, expected values derived by hand.
        tv.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  0));
        tv.push_back(mk(1'b1, 32'h1,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  0));
        tv.push_back(mk(1'b1, 32'h2,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h1,  0));
        tv.push_back(mk(1'b1, 32'h3,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h2,  0));
        tv.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h3,  0));
        tv.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  0));
        tv.push_back(mk(1'b1, 32'hA,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  0));
        tv.push_back(mk(1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA,  0));
        tv.push_back(mk(1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA,  1));
        tv.push_back(mk(1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA,  2));
        tv.push_back(mk(1'b1, 32'hC,  1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'hA,  3));
        tv.push_back(mk(1'b1, 32'hC,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hB,  3));
        tv.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hC,  3));
        tv.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  3));
        tv.push_back(mk(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  3));
        tv.push_back(mk(1'b1, 32'h12, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h11, 3));
        tv.push_back(mk(1'b1, 32'hD,  1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 32'h11, 4));
        tv.push_back(mk(1'b1, 32'h21, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  5));
        tv.push_back(mk(1'b1, 32'hD,  1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 32'h21, 5));
        tv.push_back(mk(1'b1, 32'h31, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  6));
        tv.push_back(mk(1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 32'h31, 6));
        tv.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  6));

        do_reset();
        chk("rst_a_data", a_out_data, 32'h0);
        chk("rst_b_data", b_out_data, 32'h0);
        repeat (3) tick();

        // Vector table on A (B idles, still model-checked).
        tv_en = 1'b1;
        for (int i = 0; i < tv.size(); i++) begin
            tv_cur      = tv[i];
            a_in_valid  = tv[i].iv;
            a_in_data   = tv[i].d;
            a_out_ready = tv[i].ordy;
            a_flush     = tv[i].fl;
            tick();
        end
        tv_en = 1'b0;

        // Counter saturation: fill A/C and stall for 20+ cycles.
        a_flush = 1'b0; a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'h40; tick();
        a_in_data = 32'h41; tick();
        a_in_valid = 1'b0;
        repeat (20) tick();
        chk("c_sat", 32'(c_stall), 32'd15);
        a_cnt_clr = 1'b1; tick();
        a_cnt_clr = 1'b0;
        chk("c_clr", 32'(c_stall), 32'd0);
        chk("a_clr", 32'(a_stall), 32'd0);
        tick();

        // Asynchronous reset while FULL: outputs clear before any edge.
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(a_out_valid), 32'd0);
        chk("arst_ready", 32'(a_in_ready), 32'd1);
        chk("arst_occ", 32'(a_occ), 32'd0);
        chk("arst_data", a_out_data, 32'h0);
        chk("arst_stall", 32'(a_stall), 32'd0);
        do_reset();

        // Single-register mode: continuous input, out_ready 1,0,1 pattern.
        nxt = 32'h10;
        b_in_valid = 1'b1;
        b_got.delete();
        for (int i = 0; i < 15; i++) begin
            logic acc;
            b_out_ready = (i % 3) != 1;
            b_in_data   = nxt;
            acc = (qb.size() == 0) || b_out_ready;
            tick();
            if (acc) nxt = nxt + 32'h1;
        end
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        repeat (2) tick();
        chk("b_count", b_got.size(), nxt - 32'h10);
        for (int i = 0; i < b_got.size(); i++) chk("b_order", b_got[i], 32'h10 + 32'(i));

        // Randomized traffic on all instances against the model.
        for (int i = 0; i < 400; i++) begin
            a_in_valid  = 1'($urandom_range(0, 1));
            a_in_data   = $urandom;
            a_out_ready = ($urandom_range(0, 3) != 0);
            a_flush     = ($urandom_range(0, 19) == 0);
            a_cnt_clr   = ($urandom_range(0, 29) == 0);
            b_in_valid  = 1'($urandom_range(0, 1));
            b_in_data   = $urandom;
            b_out_ready = ($urandom_range(0, 2) != 0);
            b_flush     = ($urandom_range(0, 19) == 0);
            b_cnt_clr   = ($urandom_range(0, 29) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
